tlp_buffer: RTL and testbench

TLP_BUFFER -- requirements
Module: tlp_buffer

---
 rtl/tlp_pkg.sv | 17 +
 rtl/tlp_fifo.sv | 57 +++++
 rtl/tlp_buffer.sv | 161 ++++++++++++++++
 tb/tb_tlp_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared word layout, field positions and request-FSM state encoding for the TLP buffer.
package tlp_pkg;

    localparam int TLP_WORD_W = 35;
    localparam int MW_BIT     = 34;
    localparam int LINK_HI    = 33;
    localparam int LINK_LO    = 32;
    localparam int DATA_HI    = 31;
    localparam int TLP_CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } req_state_e;

endpackage

// File: rtl/tlp_fifo.sv
// Synchronous FIFO with combinational head read and occupancy count output.
module tlp_fifo
    import tlp_pkg::*;
#(
    parameter  int WIDTH = TLP_WORD_W,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tlp_buffer.sv
// Requests single words from the upstream link router, buffers them and streams TLPs downstream.
//   state | meaning
//   IDLE  | no request outstanding; issue one when the FIFO has room
//   REQ   | buffer_ready pulse cycle; a word may already arrive here
//   WAIT  | waiting up to WAIT_MAX cycles for the requested word
module tlp_buffer
    import tlp_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WAIT_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [TLP_WORD_W-1:0]       data_in,
    output logic                        buffer_ready,
    output logic [DATA_HI:0]            out_data,
    output logic [LINK_HI-LINK_LO:0]    out_link,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TLP_CNT_W-1:0]        tlp_count,
    output logic                        err_unsolicited,
    output logic                        err_link
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    req_state_e                  state_q, state_d;
    logic [WCW-1:0]              wcnt_q, wcnt_d;
    logic                        started_q;
    logic                        buffer_ready_q;
    logic [TLP_CNT_W-1:0]        tlp_cnt_q;
    logic                        at_start_q;
    logic [LINK_HI-LINK_LO:0]    link_q;
    logic                        err_unsol_q;
    logic                        err_link_q;

    logic                        word_present;
    logic                        push;
    logic                        pop;
    logic                        unsol;
    logic [TLP_WORD_W-1:0]       fifo_head;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [CW-1:0]               fifo_count;
    logic                        head_last;
    logic                        tc_inc;
    logic                        tc_dec;

    assign word_present = |data_in;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        push    = 1'b0;
        unsol   = 1'b0;
        case (state_q)
            IDLE: begin
                unsol = word_present;
                if (started_q && (fifo_count < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                if (word_present) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (word_present) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // started_q holds off the first request until the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            wcnt_q         <= '0;
            started_q      <= 1'b0;
            buffer_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            started_q      <= 1'b1;
            buffer_ready_q <= (state_d == REQ);
        end
    end

    tlp_fifo #(
        .WIDTH (TLP_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (data_in),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign head_last = !fifo_head[MW_BIT];
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_head[DATA_HI:0]         : '0;
    assign out_link  = out_valid ? fifo_head[LINK_HI:LINK_LO]   : '0;
    assign out_last  = out_valid && head_last;

    assign tc_inc = push && !data_in[MW_BIT];
    assign tc_dec = pop && head_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tlp_cnt_q   <= '0;
            at_start_q  <= 1'b1;
            link_q      <= '0;
            err_unsol_q <= 1'b0;
            err_link_q  <= 1'b0;
        end else begin
            case ({tc_inc, tc_dec})
                2'b10:   tlp_cnt_q <= tlp_cnt_q + 1'b1;
                2'b01:   tlp_cnt_q <= tlp_cnt_q - 1'b1;
                default: tlp_cnt_q <= tlp_cnt_q;
            endcase
            if (unsol) err_unsol_q <= 1'b1;
            // A mismatching word is still stored; only the flag records the fault.
            if (push) begin
                if (at_start_q) begin
                    link_q <= data_in[LINK_HI:LINK_LO];
                end else if (data_in[LINK_HI:LINK_LO] != link_q) begin
                    err_link_q <= 1'b1;
                end
                at_start_q <= !data_in[MW_BIT];
            end
        end
    end

    assign buffer_ready    = buffer_ready_q;
    assign tlp_count       = tlp_cnt_q;
    assign err_unsolicited = err_unsol_q;
    assign err_link        = err_link_q;

    a_no_full_write: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_tlp_buffer.sv
// Randomised bench for tlp_buffer against a queue-based model of the request/buffer protocol.
module tb_tlp_buffer;

    localparam int DEPTH    = 16;
    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [34:0] data_in;
    logic        buffer_ready;
    logic [31:0] out_data;
    logic [1:0]  out_link;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  tlp_count;
    logic        err_unsolicited;
    logic        err_link;

    tlp_buffer #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .buffer_ready    (buffer_ready),
        .out_data        (out_data),
        .out_link        (out_link),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .tlp_count       (tlp_count),
        .err_unsolicited (err_unsolicited),
        .err_link        (err_link)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: FIFO contents, request window position (-2 after reset, -1 idle, 0 = pulse, 1..WAIT_MAX waiting)
    logic [34:0] q_m[$];
    int          phase;
    int          resp_at;
    int          sync_cnt;
    bit          at_start_m;
    logic [1:0]  link_m;
    bit          e_unsol_m;
    bit          e_link_m;

    int          k_delay;
    int          k_ready;
    bit          k_rand_src;
    bit          k_single;
    logic [34:0] src_q[$];
    bit          has_unsol;
    logic [34:0] unsol_word;

    int br_pulses = 0;
    int pushes    = 0;
    int obs_pops  = 0;
    int peak_tc   = 0;
    bit last_br   = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [34:0] mk(input logic mw, input logic [1:0] lk, input logic [31:0] dw);
        return {mw, lk, dw};
    endfunction

    task automatic model_reset();
        q_m.delete();
        src_q.delete();
        phase      = -2;
        sync_cnt   = 0;
        resp_at    = -1;
        at_start_m = 1'b1;
        link_m     = 2'd0;
        e_unsol_m  = 1'b0;
        e_link_m   = 1'b0;
        has_unsol  = 1'b0;
    endtask

    task automatic step();
        logic [34:0] h;
        logic [34:0] w;
        int          tc;
        int          qn;
        bit          rdy;
        bit          push;
        bit          pop;
        @(negedge clk);
        qn = q_m.size();
        h  = (qn != 0) ? q_m[0] : 35'd0;
        tc = 0;
        foreach (q_m[i]) if (!q_m[i][34]) tc++;
        chk("out_valid", int'(out_valid), int'(qn != 0));
        chk("out_data", int'(out_data), int'(h[31:0]));
        chk("out_link", int'(out_link), int'(h[33:32]));
        chk("out_last", int'(out_last), int'((qn != 0) && !h[34]));
        chk("tlp_count", int'(tlp_count), tc);
        chk("err_unsolicited", int'(err_unsolicited), int'(e_unsol_m));
        chk("err_link", int'(err_link), int'(e_link_m));
        if (phase == -2) begin
            if (sync_cnt == 0) begin
                chk("br_first_edge", int'(buffer_ready), 0);
            end else if (buffer_ready || sync_cnt >= 4) begin
                chk("br_after_reset", int'(buffer_ready), 1);
                phase = 0;
            end
            sync_cnt++;
        end else begin
            chk("buffer_ready", int'(buffer_ready), int'(phase == 0));
        end
        last_br = buffer_ready;
        if (buffer_ready) br_pulses++;
        if (int'(tlp_count) > peak_tc) peak_tc = int'(tlp_count);

        w = '0;
        if (phase == 0) begin
            if (k_delay == -2 || (src_q.size() == 0 && !k_rand_src)) resp_at = -1;
            else if (k_delay == -1)
                resp_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, WAIT_MAX));
            else resp_at = k_delay;
        end
        if (phase >= 0 && phase == resp_at) begin
            if (src_q.size() != 0) begin
                w = src_q.pop_front();
            end else begin
                w[31:0]  = $urandom;
                w[34]    = k_single ? 1'b0 : ($urandom_range(0, 4) < 3);
                w[33:32] = at_start_m ? 2'($urandom_range(0, 3))
                         : (($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : link_m);
                if (w == '0) w[0] = 1'b1;
            end
        end else if (phase == -1 && has_unsol) begin
            w         = unsol_word;
            has_unsol = 1'b0;
        end
        rdy       = (k_ready == 2) ? ($urandom_range(0, 1) == 1) : (k_ready == 1);
        data_in   = w;
        out_ready = rdy;
        if (out_valid && rdy) obs_pops++;

        push = (phase >= 0) && (w != '0);
        pop  = (qn != 0) && rdy;
        if (phase == -1 && w != '0) e_unsol_m = 1'b1;
        if (push) begin
            if (!at_start_m && w[33:32] != link_m) e_link_m = 1'b1;
            if (at_start_m) link_m = w[33:32];
            at_start_m = !w[34];
        end
        if (pop) void'(q_m.pop_front());
        if (push) begin
            q_m.push_back(w);
            pushes++;
        end
        if (phase == -2) begin
            // still waiting for the first request after reset
        end else if (push || phase == WAIT_MAX) phase = -1;
        else if (phase >= 0) phase++;
        else phase = (qn < DEPTH) ? 0 : -1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until_pushes(input int target, input int bound, input string tag);
        int k;
        k = 0;
        while (pushes < target && k < bound) begin
            step();
            k++;
        end
        chk(tag, int'(pushes >= target), 1);
    endtask

    // Asynchronous assert between edges, immediate output check, release one cycle later.
    task automatic apply_reset();
        #2;
        reset     = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_link", int'(out_link), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_tlp_count", int'(tlp_count), 0);
        chk("rst_buffer_ready", int'(buffer_ready), 0);
        chk("rst_err_unsol", int'(err_unsolicited), 0);
        chk("rst_err_link", int'(err_link), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int p0;
        int o0;
        int k;
        reset      = 1'b0;
        data_in    = '0;
        out_ready  = 1'b0;
        k_delay    = 2;
        k_ready    = 1;
        k_rand_src = 1'b0;
        k_single   = 1'b0;
        apply_reset();

        // Basic handshake: one 3-word TLP, each word answered 2 cycles after its request
        src_q = {mk(1'b1, 2'd0, 32'h0400_0001), mk(1'b1, 2'd0, 32'h0000_0002), mk(1'b0, 2'd0, 32'h0000_0003)};
        br_pulses = 0;
        obs_pops  = 0;
        peak_tc   = 0;
        run_until_pushes(3, 60, "basic_done");
        chk("basic_pulses", br_pulses, 3);
        run(4);
        chk("basic_tlp_peak", peak_tc, 1);
        chk("basic_tlp_end", int'(tlp_count), 0);
        chk("basic_pops", obs_pops, 3);

        // Timeout: no responses at all
        k_delay = -2;
        k = 0;
        while (!last_br && k < 10) begin
            step();
            k++;
        end
        chk("timeout_sync", int'(last_br), 1);
        n0 = br_pulses;
        p0 = pushes;
        run(35);
        chk("timeout_pulses", br_pulses - n0 + 1, 36 / (WAIT_MAX + 2));
        chk("timeout_no_write", int'(out_valid), 0);

        // Fill: single-word TLPs with the sink stalled
        k_delay    = 1;
        k_rand_src = 1'b1;
        k_single   = 1'b1;
        k_ready    = 0;
        k = 0;
        while (q_m.size() < DEPTH && k < 200) begin
            step();
            k++;
        end
        n0 = br_pulses;
        run(8);
        chk("fill_tlp_count", int'(tlp_count), DEPTH);
        chk("fill_no_req", br_pulses - n0, 0);
        k_ready = 1;
        step();
        k_ready = 0;
        k = 0;
        last_br = 1'b0;
        while (!last_br && k < 3) begin
            step();
            k++;
        end
        chk("fill_rereq", int'(last_br), 1);

        // Concurrent push/pop with random sink readiness and response delays
        apply_reset();
        k_delay    = -1;
        k_ready    = 2;
        k_single   = 1'b0;
        k_rand_src = 1'b1;
        p0 = pushes;
        o0 = obs_pops;
        run_until_pushes(p0 + 100, 3000, "concurrent_done");
        k_delay = -2;
        k_ready = 1;
        run(20);
        chk("concurrent_drained", int'(out_valid), 0);
        chk("concurrent_no_loss", obs_pops - o0, pushes - p0);

        // Errors: unsolicited word in IDLE, then a link change inside a TLP
        apply_reset();
        k_delay    = -2;
        k_ready    = 1;
        k_rand_src = 1'b0;
        unsol_word = mk(1'b1, 2'd0, 32'h4000_0001);
        has_unsol  = 1'b1;
        run(12);
        chk("unsol_flag", int'(err_unsolicited), 1);
        chk("unsol_not_stored", int'(out_valid), 0);
        src_q = {mk(1'b1, 2'd1, 32'h0000_00A1), mk(1'b0, 2'd2, 32'h0000_00A2)};
        k_delay = 1;
        p0 = pushes;
        o0 = obs_pops;
        run_until_pushes(p0 + 2, 40, "link_words");
        run(3);
        chk("link_flag", int'(err_link), 1);
        chk("link_both_stored", obs_pops - o0, 2);

        // Reset mid-TLP with 5 words stored
        k_ready = 0;
        k_delay = 0;
        for (int i = 0; i < 5; i++) src_q.push_back(mk(1'b1, 2'd3, 32'(i + 1)));
        p0 = pushes;
        run_until_pushes(p0 + 5, 60, "rst_fill");
        run(2);
        chk("rst_pre_valid", int'(out_valid), 1);
        apply_reset();

        k_delay    = -1;
        k_ready    = 2;
        k_rand_src = 1'b1;
        run(150);
        k_delay = -2;
        k_ready = 1;
        run(20);
        chk("tail_drained", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
